fejkon_led_ctrl: RTL and testbench

- Per-port front-panel LED controller for the fejkon status LEDs.
- Takes per-port link state and activity strobes and runs a per-port mode FSM (DOWN/UP/ACT/FLAP) with built-in link-flap detection.
- Drives each LED from one shared blink time base, so all ports blink in phase.
- Sits between the FC port status logic and the board LED pins.

---
 rtl/fejkon_led_pkg.sv | 23 ++
 rtl/fejkon_led_ctrl_timebase.sv | 46 ++++
 rtl/fejkon_led_ctrl.sv | 133 +++++++++++++
 tb/tb_fejkon_led_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fejkon_led_pkg.sv
// Shared types and widths for the fejkon front-panel LED controller.
package fejkon_led_pkg;

    typedef enum logic [1:0] {
        LED_DOWN,
        LED_UP,
        LED_ACT,
        LED_FLAP
    } led_state_t;

    localparam int TickCntW = 32;
    localparam int HoldCntW = 16;

    function automatic logic decode_led(led_state_t s, logic fast_phase, logic slow_phase);
        case (s)
            LED_UP:   return 1'b1;
            LED_ACT:  return ~fast_phase;
            LED_FLAP: return slow_phase;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fejkon_led_ctrl_timebase.sv
// Shared blink time base: tick prescaler plus fast/slow phase toggles,
// so every port LED blinks in phase.
module led_timebase
    import fejkon_led_pkg::*;
#(
    parameter logic [31:0] TickDiv   = 32'd12_500_000,
    parameter logic [7:0]  SlowTicks = 8'd5
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic fast_phase,
    output logic slow_phase
);

    logic [TickCntW-1:0] prescaler;
    logic [7:0]          slow_cnt;
    logic                wrap;

    assign wrap = (prescaler == TickDiv - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            slow_cnt   <= '0;
            tick       <= 1'b0;
            fast_phase <= 1'b0;
            slow_phase <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                prescaler  <= '0;
                fast_phase <= ~fast_phase;
                if (slow_cnt == SlowTicks - 8'd1) begin
                    slow_cnt   <= '0;
                    slow_phase <= ~slow_phase;
                end else begin
                    slow_cnt <= slow_cnt + 8'd1;
                end
            end else begin
                prescaler <= prescaler + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fejkon_led_ctrl.sv
// Per-port status LED controller with link-flap detection.
// Optional FEJKON_LED_LAMP_TEST_EN adds a lamp_test input forcing all LEDs on.
//
// state     | meaning
// LED_DOWN  | link down, LED off
// LED_UP    | link up and idle, LED steady on
// LED_ACT   | link up with recent activity, LED blinks on fast phase
// LED_FLAP  | link flapping, LED blinks on slow phase until quiet
module fejkon_led_ctrl
    import fejkon_led_pkg::*;
#(
    parameter int          Ports           = 4,
    parameter logic [31:0] TickDiv         = 32'd12_500_000,
    parameter logic [7:0]  SlowTicks       = 8'd5,
    parameter logic [7:0]  ActHoldTicks    = 8'd2,
    parameter logic [15:0] FlapWindowTicks = 16'd50,
    parameter logic [3:0]  MaxStrikes      = 4'd3,
    parameter logic [15:0] FlapHoldTicks   = 16'd100
) (
    input  logic             clk,
`ifdef FEJKON_LED_LAMP_TEST_EN
    input  logic             lamp_test,
`endif
    input  logic             reset,
    input  logic [Ports-1:0] link_up,
    input  logic [Ports-1:0] activity,
    output logic [Ports-1:0] led,
    output logic [Ports-1:0] flapping,
    output logic             tick
);

    if (TickDiv < 32'd2) begin : g_bad_tickdiv
        $error("fejkon_led_ctrl: TickDiv must be >= 2");
    end

    logic fast_phase;
    logic slow_phase;
    logic lamp;

`ifdef FEJKON_LED_LAMP_TEST_EN
    assign lamp = lamp_test;
`else
    assign lamp = 1'b0;
`endif

    led_timebase #(
        .TickDiv   (TickDiv),
        .SlowTicks (SlowTicks)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .fast_phase (fast_phase),
        .slow_phase (slow_phase)
    );

    for (genvar i = 0; i < Ports; i++) begin : g_port
        led_state_t          state;
        logic                link_r;
        logic [7:0]          act_cnt;
        logic [HoldCntW-1:0] win_cnt;
        logic [HoldCntW-1:0] hold_cnt;
        logic [3:0]          strikes;
        logic                led_q;
        logic                flap_q;
        logic                edge_det;
        logic                trip;

        assign edge_det    = link_up[i] ^ link_r;
        assign trip        = (strikes == 4'd0) && (win_cnt != '0);
        assign led[i]      = led_q;
        assign flapping[i] = flap_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state    <= LED_DOWN;
                link_r   <= 1'b0;
                act_cnt  <= '0;
                win_cnt  <= '0;
                hold_cnt <= '0;
                strikes  <= MaxStrikes;
                led_q    <= 1'b0;
                flap_q   <= 1'b0;
            end else begin
                link_r <= link_up[i];
                led_q  <= lamp | decode_led(state, fast_phase, slow_phase);

                if (activity[i])
                    act_cnt <= ActHoldTicks;
                else if (tick && act_cnt != '0)
                    act_cnt <= act_cnt - 8'd1;

                // An edge landing on the closing tick still strikes the old window.
                if (trip) begin
                    win_cnt <= '0;
                    strikes <= MaxStrikes;
                end else if (edge_det && win_cnt == '0) begin
                    win_cnt <= FlapWindowTicks;
                    strikes <= MaxStrikes - 4'd1;
                end else begin
                    if (edge_det && strikes != 4'd0)
                        strikes <= strikes - 4'd1;
                    if (tick && win_cnt != '0)
                        win_cnt <= win_cnt - 16'd1;
                end

                if (trip) begin
                    state    <= LED_FLAP;
                    hold_cnt <= FlapHoldTicks;
                    flap_q   <= 1'b1;
                end else if (state == LED_FLAP) begin
                    if (edge_det) begin
                        hold_cnt <= FlapHoldTicks;
                    end else if (hold_cnt == '0) begin
                        state  <= link_up[i] ? LED_UP : LED_DOWN;
                        flap_q <= 1'b0;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end else begin
                    flap_q <= 1'b0;
                    if (!link_up[i])
                        state <= LED_DOWN;
                    else if (activity[i] || act_cnt != '0)
                        state <= LED_ACT;
                    else
                        state <= LED_UP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fejkon_led_ctrl.sv
// Randomized and directed bench for fejkon_led_ctrl against a tick-count reference model.
module tb_fejkon_led_ctrl;

    localparam int TD = 4;
    localparam int ST = 2;
    localparam int AH = 2;
    localparam int FW = 10;
    localparam int MS = 3;
    localparam int FH = 5;

    localparam int M_DOWN = 10;
    localparam int M_UP   = 11;
    localparam int M_ACT  = 12;
    localparam int M_FLAP = 13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] link_up = '0;
    logic [3:0] activity = '0;
    logic       lamp_test = 1'b0;
    logic [3:0] led;
    logic [3:0] flapping;
    logic       tick;

    fejkon_led_ctrl #(
        .Ports           (4),
        .TickDiv         (32'd4),
        .SlowTicks       (8'd2),
        .ActHoldTicks    (8'd2),
        .FlapWindowTicks (16'd10),
        .MaxStrikes      (4'd3),
        .FlapHoldTicks   (16'd5)
    ) dut (
        .clk       (clk),
`ifdef FEJKON_LED_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .reset     (reset),
        .link_up   (link_up),
        .activity  (activity),
        .led       (led),
        .flapping  (flapping),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: phases come from the count of clock edges since reset;
    // flap detection counts edges inside an open window of ticks.
    int cyc;
    int m_link[4];
    int m_act[4];
    int m_win[4];
    int m_edges[4];
    int m_hold[4];
    int m_mode[4];
    logic [3:0] exp_led;
    logic [3:0] exp_flap;
    logic       exp_tick;

    function automatic void model_reset();
        cyc = 0;
        for (int p = 0; p < 4; p++) begin
            m_link[p]  = 0;
            m_act[p]   = 0;
            m_win[p]   = 0;
            m_edges[p] = 0;
            m_hold[p]  = 0;
            m_mode[p]  = M_DOWN;
        end
        exp_led  = '0;
        exp_flap = '0;
        exp_tick = 1'b0;
    endfunction

    initial model_reset();

    always @(posedge clk) begin
        if (!reset) begin
            bit tk, fast, slow, e, trip, busy, lnk;
            tk   = (cyc > 0) && (cyc % TD == 0);
            fast = ((cyc / TD) % 2) == 1;
            slow = ((cyc / (TD * ST)) % 2) == 1;
            for (int p = 0; p < 4; p++) begin
                lnk  = link_up[p];
                e    = (int'(lnk) != m_link[p]);
                trip = (m_edges[p] >= MS) && (m_win[p] > 0);
                busy = activity[p] || (m_act[p] > 0);

                case (m_mode[p])
                    M_UP:    exp_led[p] = 1'b1;
                    M_ACT:   exp_led[p] = !fast;
                    M_FLAP:  exp_led[p] = slow;
                    default: exp_led[p] = 1'b0;
                endcase
                if (lamp_test) exp_led[p] = 1'b1;

                if (activity[p]) m_act[p] = AH;
                else if (tk && m_act[p] > 0) m_act[p]--;

                if (trip) begin
                    m_win[p] = 0;
                    m_edges[p] = 0;
                end else if (e && m_win[p] == 0) begin
                    m_win[p] = FW;
                    m_edges[p] = 1;
                end else begin
                    if (e) m_edges[p]++;
                    if (tk && m_win[p] > 0) m_win[p]--;
                end

                if (trip) begin
                    m_mode[p] = M_FLAP;
                    m_hold[p] = FH;
                end else if (m_mode[p] == M_FLAP) begin
                    if (e) m_hold[p] = FH;
                    else if (m_hold[p] == 0) m_mode[p] = lnk ? M_UP : M_DOWN;
                    else if (tk) m_hold[p]--;
                end else begin
                    m_mode[p] = !lnk ? M_DOWN : (busy ? M_ACT : M_UP);
                end
                exp_flap[p] = (m_mode[p] == M_FLAP);
                m_link[p]   = int'(lnk);
            end
            cyc++;
            exp_tick = (cyc % TD == 0);
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("led", 32'(led), 32'(exp_led));
            chk("flapping", 32'(flapping), 32'(exp_flap));
            chk("tick", 32'(tick), 32'(exp_tick));
        end
    endtask

    task automatic tick_latency(input string tag);
        int k;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            step(1);
            k++;
            if (tick) break;
        end
        chk(tag, 32'(k), 32'd4);
    endtask

    initial begin
        step(3);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_flap", 32'(flapping), 32'd0);
        reset = 1'b0;
        tick_latency("tick_first");
        step(5);

        // link up on port 0: led follows two edges later
        link_up[0] = 1'b1;
        step(1);
        chk("up_lat1", 32'(led[0]), 32'd0);
        step(1);
        chk("up_lat2", 32'(led[0]), 32'd1);
        chk("up_others", 32'(led[3:1]), 32'd0);

        // activity on port 1
        link_up[1] = 1'b1;
        step(6);
        chk("p1_up", 32'(led[1]), 32'd1);
        activity[1] = 1'b1;
        step(1);
        activity[1] = 1'b0;
        step(20);
        chk("p1_steady", 32'(led[1]), 32'd1);

        // three edges on port 2 inside the window trip FLAP
        link_up[2] = 1'b1;
        step(3);
        link_up[2] = 1'b0;
        step(3);
        link_up[2] = 1'b1;
        step(1);
        chk("flap_pre", 32'(flapping[2]), 32'd0);
        step(1);
        chk("flap_set", 32'(flapping[2]), 32'd1);
        step(12);
        link_up[2] = 1'b0;
        step(17);
        chk("flap_hold", 32'(flapping[2]), 32'd1);
        step(9);
        chk("flap_exit", 32'(flapping[2]), 32'd0);
        chk("flap_exit_led", 32'(led[2]), 32'd0);

        // two edges, window expires, two more: no flap
        link_up[3] = 1'b1;
        step(3);
        link_up[3] = 1'b0;
        step(48);
        link_up[3] = 1'b1;
        step(3);
        link_up[3] = 1'b0;
        step(6);
        chk("no_flap", 32'(flapping[3]), 32'd0);

        // randomized segments with decreasing flap rate
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 600; c++) begin
                for (int p = 0; p < 4; p++) begin
                    case (seg)
                        0: if ($urandom_range(3) == 0) link_up[p] = ~link_up[p];
                        1: if ($urandom_range(15) == 0) link_up[p] = ~link_up[p];
                        2: if ($urandom_range(63) == 0) link_up[p] = ~link_up[p];
                        default: ;
                    endcase
                    activity[p] = ($urandom_range(7) == 0);
                end
`ifdef FEJKON_LED_LAMP_TEST_EN
                if ($urandom_range(31) == 0) lamp_test = ~lamp_test;
`endif
                step(1);
            end
        end
        activity = '0;
        lamp_test = 1'b0;
        link_up = '0;
        step(120);

        // force port 0 into FLAP, then reset mid-run
        for (int t = 0; t < 3; t++) begin
            link_up[0] = ~link_up[0];
            step(2);
        end
        step(2);
        chk("pre_reset_flap", 32'(flapping[0]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_led", 32'(led), 32'd0);
        chk("async_flap", 32'(flapping), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        model_reset();
        link_up = '0;
        step(2);
        reset = 1'b0;
        tick_latency("tick_after_reset");
        step(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
